csr_file: RTL and testbench



---
 rtl/csr_pkg.sv | 48 ++++
 rtl/csr_file_if.sv | 41 ++++
 rtl/csr_counter64.sv | 39 +++
 rtl/csr_file.sv | 170 +++++++++++++++++
 tb/tb_csr_file.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// ============================================================================
// csr_pkg : shared address map, op encodings and reset constants for csr_file
// Revision: 1.0
// ============================================================================
`default_nettype none

package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [31:0] MISA_VALUE    = 32'h4000_0100;
  localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LO   = 11;
  localparam int MSTATUS_MPP_HI   = 12;

endpackage

`default_nettype wire

// File: rtl/csr_file_if.sv
// ============================================================================
// csr_file_if : EX-stage CSR request, trap/mret controls and CSR results
// Revision: 1.0
// ============================================================================
`default_nettype none

interface csr_file_if;
  logic [11:0] CSR_addr_EX;
  logic [1:0]  CSR_op_EX;
  logic [31:0] CSR_zimm_EX;
  logic        CSR_zimm_or_reg_EX;
  logic        CSR_write_en_EX;
  logic [31:0] rs1_data_EX;
  logic        stall_EX;
  logic        instret_inc;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic [31:0] trap_tval;
  logic        mret_valid;
  logic [31:0] CSR_rdata;
  logic        CSR_illegal;
  logic [31:0] redirect_pc;
  logic        mie_global;

  modport master (
    output CSR_addr_EX, CSR_op_EX, CSR_zimm_EX, CSR_zimm_or_reg_EX, CSR_write_en_EX,
           rs1_data_EX, stall_EX, instret_inc, trap_valid, trap_pc, trap_cause,
           trap_tval, mret_valid,
    input  CSR_rdata, CSR_illegal, redirect_pc, mie_global
  );

  modport slave (
    input  CSR_addr_EX, CSR_op_EX, CSR_zimm_EX, CSR_zimm_or_reg_EX, CSR_write_en_EX,
           rs1_data_EX, stall_EX, instret_inc, trap_valid, trap_pc, trap_cause,
           trap_tval, mret_valid,
    output CSR_rdata, CSR_illegal, redirect_pc, mie_global
  );
endinterface

`default_nettype wire

// File: rtl/csr_counter64.sv
// ============================================================================
// csr_counter64 : 64-bit counter; a write to either half beats the increment
// Revision: 1.0
// ============================================================================
`default_nettype none

module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q;
  logic [63:0] count_d;

  always_comb begin
    count_d = count_q;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) count_d[31:0]  = wdata_i;
      if (wr_hi_i) count_d[63:32] = wdata_i;
    end else if (inc_i) begin
      count_d = count_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/csr_file.sv
// ============================================================================
// csr_file : M-mode CSR storage, read-modify-write and trap/mret state
// Optional: CSR_COUNTERS_EN adds mcycle/minstret and their user shadows.
// Revision: 1.0
// ============================================================================
`default_nettype none

module csr_file
  import csr_pkg::*;
#(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst_n,
  csr_file_if.slave  bus
);

  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mie_csr_q, mie_csr_d;
  logic [31:2] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:2] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;

  logic [31:0] rdata, src, wdata;
  logic        implemented, illegal, commit;
  csr_op_e     op;
  logic [63:0] mcycle, minstret;
  logic        unused_ok;

  assign op = csr_op_e'(bus.CSR_op_EX);

  always_comb begin
    rdata       = '0;
    implemented = 1'b1;
    case (bus.CSR_addr_EX)
      CSR_MSTATUS:  rdata = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
      CSR_MISA:     rdata = MISA_VALUE;
      CSR_MIE:      rdata = mie_csr_q;
      CSR_MTVEC:    rdata = {mtvec_q, 2'b00};
      CSR_MSCRATCH: rdata = mscratch_q;
      CSR_MEPC:     rdata = {mepc_q, 2'b00};
      CSR_MCAUSE:   rdata = mcause_q;
      CSR_MTVAL:    rdata = mtval_q;
      CSR_MIP:      rdata = '0;
      CSR_MCYCLE,   CSR_CYCLE:    rdata = mcycle[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:   rdata = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:  rdata = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: rdata = minstret[63:32];
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: rdata = '0;
      CSR_MHARTID:  rdata = HART_ID;
      default:      implemented = 1'b0;
    endcase
  end

  assign illegal = !implemented ||
                   (bus.CSR_write_en_EX && (bus.CSR_addr_EX[11:10] == 2'b11));

  assign src = bus.CSR_zimm_or_reg_EX ? bus.CSR_zimm_EX : bus.rs1_data_EX;

  always_comb begin
    case (op)
      CSR_OP_RW: wdata = src;
      CSR_OP_RS: wdata = rdata | src;
      CSR_OP_RC: wdata = rdata & ~src;
      default:   wdata = rdata;
    endcase
  end

  assign commit = bus.CSR_write_en_EX && (op != CSR_OP_NONE) && !bus.stall_EX &&
                  !illegal && !bus.trap_valid;

  // Trap beats mret and writes; a CSR write to mstatus beats a coincident mret.
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_csr_d      = mie_csr_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    if (bus.trap_valid) begin
      mepc_d         = bus.trap_pc[31:2];
      mcause_d       = bus.trap_cause;
      mtval_d        = bus.trap_tval;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (bus.mret_valid) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end
    if (commit) begin
      case (bus.CSR_addr_EX)
        CSR_MSTATUS: begin
          mstatus_mie_d  = wdata[MSTATUS_MIE_BIT];
          mstatus_mpie_d = wdata[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:      mie_csr_d  = wdata;
        CSR_MTVEC:    mtvec_d    = wdata[31:2];
        CSR_MSCRATCH: mscratch_d = wdata;
        CSR_MEPC:     mepc_d     = wdata[31:2];
        CSR_MCAUSE:   mcause_d   = wdata;
        CSR_MTVAL:    mtval_d    = wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_csr_q      <= '0;
      mtvec_q        <= MTVEC_RESET[31:2];
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_csr_q      <= mie_csr_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
    end
  end

`ifdef CSR_COUNTERS_EN
  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (1'b1),
    .wr_lo_i (commit && (bus.CSR_addr_EX == CSR_MCYCLE)),
    .wr_hi_i (commit && (bus.CSR_addr_EX == CSR_MCYCLEH)),
    .wdata_i (wdata),
    .count_o (mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (bus.instret_inc),
    .wr_lo_i (commit && (bus.CSR_addr_EX == CSR_MINSTRET)),
    .wr_hi_i (commit && (bus.CSR_addr_EX == CSR_MINSTRETH)),
    .wdata_i (wdata),
    .count_o (minstret)
  );

  assign unused_ok = ^bus.trap_pc[1:0];
`else
  assign mcycle    = '0;
  assign minstret  = '0;
  assign unused_ok = ^{bus.trap_pc[1:0], bus.instret_inc};
`endif

  assign bus.CSR_rdata   = rdata;
  assign bus.CSR_illegal = illegal;
  assign bus.redirect_pc = bus.trap_valid ? {mtvec_q, 2'b00} : {mepc_q, 2'b00};
  assign bus.mie_global  = mstatus_mie_q;

endmodule

`default_nettype wire

// File: tb/tb_csr_file.sv
// ============================================================================
// tb_csr_file : directed scoreboard bench for csr_file
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_csr_file;

  logic clk   = 1'b1;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csr_file_if bus ();

  csr_file #(
    .HART_ID     (32'd0),
    .MTVEC_RESET (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       nm;
    bit          chk_rd;
    logic [31:0] rd;
    logic        ill;
    bit          chk_rp;
    logic [31:0] rp;
    bit          chk_mie;
    logic        mie;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic cmp(input string nm, input string field, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s: got %h, expected %h", nm, field, act, exp);
    end
  endtask

  // Monitor: the DUT output is valid every cycle; compare mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      cmp(e.nm, "illegal", {31'd0, bus.CSR_illegal}, {31'd0, e.ill});
      if (e.chk_rd)  cmp(e.nm, "rdata", bus.CSR_rdata, e.rd);
      if (e.chk_rp)  cmp(e.nm, "redirect_pc", bus.redirect_pc, e.rp);
      if (e.chk_mie) cmp(e.nm, "mie_global", {31'd0, bus.mie_global}, {31'd0, e.mie});
    end
  end

  task automatic idle();
    bus.CSR_addr_EX        = 12'h000;
    bus.CSR_op_EX          = 2'b00;
    bus.CSR_zimm_EX        = '0;
    bus.CSR_zimm_or_reg_EX = 1'b0;
    bus.CSR_write_en_EX    = 1'b0;
    bus.rs1_data_EX        = '0;
    bus.stall_EX           = 1'b0;
    bus.instret_inc        = 1'b0;
    bus.trap_valid         = 1'b0;
    bus.trap_pc            = '0;
    bus.trap_cause         = '0;
    bus.trap_tval          = '0;
    bus.mret_valid         = 1'b0;
  endtask

  // The unselected source carries junk so a wrong source mux shows up.
  task automatic drive(input logic [11:0] a, input logic [1:0] op, input logic use_z,
                       input logic [31:0] v);
    bus.CSR_addr_EX        = a;
    bus.CSR_op_EX          = op;
    bus.CSR_write_en_EX    = (op != 2'b00);
    bus.CSR_zimm_or_reg_EX = use_z;
    bus.CSR_zimm_EX        = use_z ? v : 32'h0000_001F;
    bus.rs1_data_EX        = use_z ? 32'hFFFF_FFFF : v;
  endtask

  task automatic push(input string nm, input bit crd, input logic [31:0] rd, input logic ill,
                      input bit crp, input logic [31:0] rp, input bit cmie, input logic mie);
    exp_t e;
    e.nm = nm; e.chk_rd = crd; e.rd = rd; e.ill = ill;
    e.chk_rp = crp; e.rp = rp; e.chk_mie = cmie; e.mie = mie;
    exp_q.push_back(e);
  endtask

  task automatic exp_rd(input string nm, input logic [31:0] rd, input logic ill);
    push(nm, 1'b1, rd, ill, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    drive(12'h301, 2'b00, 1'b0, 32'h0);
    push("reset_misa", 1'b1, 32'h4000_0100, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
    tick();
    rst_n = 1'b1;

    drive(12'h301, 2'b00, 1'b0, 32'h0); exp_rd("misa", 32'h4000_0100, 1'b0); tick();
    drive(12'h300, 2'b00, 1'b0, 32'h0); exp_rd("mstatus_rst", 32'h0000_1800, 1'b0); tick();

    drive(12'h340, 2'b01, 1'b0, 32'hDEAD_BEEF); exp_rd("rw_old", 32'h0, 1'b0); tick();
    drive(12'h340, 2'b10, 1'b1, 32'h10); exp_rd("rs_old", 32'hDEAD_BEEF, 1'b0); tick();
    drive(12'h340, 2'b11, 1'b1, 32'hF);  exp_rd("rc_old", 32'hDEAD_BEFF, 1'b0); tick();
    drive(12'h340, 2'b00, 1'b0, 32'h0);  exp_rd("rc_new", 32'hDEAD_BEF0, 1'b0); tick();

`ifndef CSR_COUNTERS_EN
    drive(12'hC00, 2'b01, 1'b0, 32'h5); exp_rd("wr_c00", 32'h0, 1'b1); tick();
    drive(12'hB00, 2'b00, 1'b0, 32'h0); exp_rd("nocnt_rd", 32'h0, 1'b0); tick();
    drive(12'hB00, 2'b01, 1'b0, 32'h77); exp_rd("nocnt_wr", 32'h0, 1'b0); tick();
    drive(12'hB00, 2'b00, 1'b0, 32'h0); exp_rd("nocnt_after", 32'h0, 1'b0); tick();
`endif
    drive(12'hF14, 2'b01, 1'b0, 32'h5); exp_rd("wr_hartid", 32'h0, 1'b1); tick();
    drive(12'hF14, 2'b00, 1'b0, 32'h0); exp_rd("hartid", 32'h0, 1'b0); tick();
    drive(12'h7C0, 2'b00, 1'b0, 32'h0); exp_rd("unimpl", 32'h0, 1'b1); tick();
    drive(12'h340, 2'b01, 1'b0, 32'h1234_5678);
    bus.stall_EX = 1'b1; exp_rd("stall_wr", 32'hDEAD_BEF0, 1'b0); tick();
    drive(12'h340, 2'b00, 1'b0, 32'h0); exp_rd("stall_hold", 32'hDEAD_BEF0, 1'b0); tick();

    drive(12'h300, 2'b10, 1'b1, 32'h8);
    push("set_mie", 1'b1, 32'h0000_1800, 1'b0, 1'b0, '0, 1'b1, 1'b0); tick();
    drive(12'h305, 2'b01, 1'b0, 32'h83);
    push("wr_mtvec", 1'b1, 32'h0, 1'b0, 1'b0, '0, 1'b1, 1'b1); tick();
    drive(12'h305, 2'b00, 1'b0, 32'h0); exp_rd("mtvec", 32'h80, 1'b0); tick();

    drive(12'h340, 2'b01, 1'b0, 32'h0000_AAAA);
    bus.trap_valid = 1'b1; bus.trap_pc = 32'h103; bus.trap_cause = 32'd11;
    bus.trap_tval = 32'h55; bus.mret_valid = 1'b1;
    push("trap", 1'b1, 32'hDEAD_BEF0, 1'b0, 1'b1, 32'h80, 1'b1, 1'b1); tick();
    drive(12'h341, 2'b00, 1'b0, 32'h0);
    push("mepc", 1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0); tick();
    drive(12'h342, 2'b00, 1'b0, 32'h0); exp_rd("mcause", 32'd11, 1'b0); tick();
    drive(12'h343, 2'b00, 1'b0, 32'h0); exp_rd("mtval", 32'h55, 1'b0); tick();
    drive(12'h300, 2'b00, 1'b0, 32'h0); exp_rd("mstatus_trap", 32'h0000_1880, 1'b0); tick();
    drive(12'h340, 2'b00, 1'b0, 32'h0); exp_rd("mscratch_kept", 32'hDEAD_BEF0, 1'b0); tick();

    drive(12'h300, 2'b00, 1'b0, 32'h0); bus.mret_valid = 1'b1;
    push("mret", 1'b1, 32'h0000_1880, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0); tick();
    drive(12'h300, 2'b00, 1'b0, 32'h0);
    push("after_mret", 1'b1, 32'h0000_1888, 1'b0, 1'b1, 32'h100, 1'b1, 1'b1); tick();

    drive(12'h301, 2'b01, 1'b0, 32'h0); exp_rd("misa_wr", 32'h4000_0100, 1'b0); tick();
    drive(12'h301, 2'b00, 1'b0, 32'h0); exp_rd("misa_warl", 32'h4000_0100, 1'b0); tick();
    drive(12'h344, 2'b01, 1'b0, 32'hFF); exp_rd("mip_wr", 32'h0, 1'b0); tick();
    drive(12'h344, 2'b00, 1'b0, 32'h0);  exp_rd("mip_warl", 32'h0, 1'b0); tick();

`ifdef CSR_COUNTERS_EN
    drive(12'hB00, 2'b01, 1'b0, 32'hFFFF_FFFF);
    push("mcycle_wr", 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0); tick();
    drive(12'hB80, 2'b01, 1'b0, 32'h0);
    push("mcycleh_wr", 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0); tick();
    drive(12'hB00, 2'b00, 1'b0, 32'h0); exp_rd("mcycle_lo", 32'hFFFF_FFFF, 1'b0); tick();
    drive(12'hB80, 2'b00, 1'b0, 32'h0); exp_rd("mcycle_carry", 32'h1, 1'b0); tick();
    drive(12'hB00, 2'b00, 1'b0, 32'h0); exp_rd("mcycle_one", 32'h1, 1'b0); tick();
    drive(12'hB00, 2'b01, 1'b0, 32'h10); exp_rd("mcycle_old", 32'h2, 1'b0); tick();
    drive(12'hB00, 2'b00, 1'b0, 32'h0);  exp_rd("write_wins", 32'h10, 1'b0); tick();
    drive(12'hC00, 2'b00, 1'b0, 32'h0);  exp_rd("cycle_shadow", 32'h11, 1'b0); tick();
    drive(12'hC80, 2'b00, 1'b0, 32'h0);  exp_rd("cycleh_shadow", 32'h1, 1'b0); tick();
`endif

    // Asynchronous reset mid-run returns everything to reset values.
    rst_n = 1'b0;
    drive(12'h340, 2'b01, 1'b0, 32'h1111_1111);
    push("rst_mscratch", 1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0); tick();
    drive(12'h305, 2'b00, 1'b0, 32'h0); exp_rd("rst_mtvec", 32'h0, 1'b0); tick();
    rst_n = 1'b1;
    drive(12'h300, 2'b00, 1'b0, 32'h0); exp_rd("rst_mstatus", 32'h0000_1800, 1'b0); tick();
    drive(12'h340, 2'b00, 1'b0, 32'h0); exp_rd("rst_no_commit", 32'h0, 1'b0); tick();

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
